tq_coef_pingpong_buf: RTL

Parametrised multi-bank coefficient buffer between the transform/quant stage and its consumers (reconstruction and CAVLC). It generalises the single 64-entry, 256-bit dual-port coefficient RAM into NUM_BANK independently addressed banks. The producer fills one bank per block while the consumers drain an earlier, completed bank. Bank ownership is managed by a pointer/count handshake, and the block provides two registered read ports with valid flags and a sticky protocol-error flag.

---
 rtl/tq_coef_pingpong_buf_if.sv | 53 +++++
 rtl/tq_coef_pingpong_buf.sv | 113 +++++++++++
 2 files changed

// File: rtl/tq_coef_pingpong_buf_if.sv
`default_nettype none
// ============================================================================
//  Module   : tq_coef_pingpong_buf_if
//  Brief    : Producer/consumer bundle for the multi-bank coefficient buffer.
//             The master side is the transform/quant producer plus the
//             reconstruction/CAVLC consumers; the slave side is the buffer.
//  Revision : 1.0  initial release
// ============================================================================
interface tq_coef_pingpong_buf_if #(
   parameter int DATA_W   = 256,
   parameter int ADDR_W   = 6,
   parameter int NUM_BANK = 2
) ();
   localparam int CNT_W = $clog2(NUM_BANK) + 1;

   // producer side
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic                wr_done;
   logic                wr_rdy;

   // consumer side, two independent read ports
   logic                rd_en_a;
   logic [ADDR_W-1:0]   rd_addr_a;
   logic [DATA_W-1:0]   rd_data_a;
   logic                rd_vld_a;
   logic                rd_en_b;
   logic [ADDR_W-1:0]   rd_addr_b;
   logic [DATA_W-1:0]   rd_data_b;
   logic                rd_vld_b;
   logic                rd_done;
   logic                rd_rdy;

   // status
   logic [CNT_W-1:0]    full_cnt;
   logic                err;

   modport master (
      output wr_en, wr_addr, wr_data, wr_done,
      output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, rd_done,
      input  wr_rdy, rd_rdy, rd_data_a, rd_vld_a, rd_data_b, rd_vld_b,
      input  full_cnt, err
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_done,
      input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, rd_done,
      output wr_rdy, rd_rdy, rd_data_a, rd_vld_a, rd_data_b, rd_vld_b,
      output full_cnt, err
   );
endinterface
`default_nettype wire

// File: rtl/tq_coef_pingpong_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tq_coef_pingpong_buf
//  Brief    : NUM_BANK-bank coefficient buffer. The producer fills the bank
//             at wr_ptr while consumers drain the oldest completed bank at
//             rd_ptr through two registered read ports. Ownership moves on
//             accepted wr_done / rd_done; misuse raises a sticky err.
//  Revision : 1.0  initial release
// ============================================================================
module tq_coef_pingpong_buf #(
   parameter int DATA_W   = 256,
   parameter int ADDR_W   = 6,
   parameter int NUM_BANK = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   tq_coef_pingpong_buf_if.slave   bus
);
   localparam int PTR_W = $clog2(NUM_BANK);
   localparam int CNT_W = PTR_W + 1;
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(NUM_BANK);

   // Pointer wrap relies on NUM_BANK being a power of two.
   generate
      if (!(NUM_BANK == 2 || NUM_BANK == 4)) begin : g_bad_num_bank
         $error("tq_coef_pingpong_buf: NUM_BANK must be 2 or 4");
      end
   endgenerate

   // Banks are stored flat; the bank pointer forms the upper address bits.
   logic [DATA_W-1:0] mem_q [NUM_BANK*DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  full_cnt_q, full_cnt_d;
   logic              err_q, err_d;
   logic              rd_vld_a_q, rd_vld_b_q;
   logic [DATA_W-1:0] rd_data_a_q, rd_data_b_q;

   logic wr_rdy, rd_rdy;
   logic wr_acc, wr_done_acc, rd_a_acc, rd_b_acc, rd_done_acc;

   // Handshake qualification and next-state of bank ownership.
   always_comb begin
      wr_rdy      = (full_cnt_q != FULL_LVL);
      rd_rdy      = (full_cnt_q != '0);
      wr_acc      = bus.wr_en   & wr_rdy;
      wr_done_acc = bus.wr_done & wr_rdy;
      rd_a_acc    = bus.rd_en_a & rd_rdy;
      rd_b_acc    = bus.rd_en_b & rd_rdy;
      rd_done_acc = bus.rd_done & rd_rdy;

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      full_cnt_d = full_cnt_q;
      if (wr_done_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_done_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_done_acc, rd_done_acc})
         2'b10:   full_cnt_d = full_cnt_q + 1'b1;
         2'b01:   full_cnt_d = full_cnt_q - 1'b1;
         default: full_cnt_d = full_cnt_q;
      endcase

      // Any strobe presented while its side has no bank is a protocol error.
      err_d = err_q
            | (bus.wr_en   & ~wr_rdy)
            | (bus.wr_done & ~wr_rdy)
            | (bus.rd_en_a & ~rd_rdy)
            | (bus.rd_en_b & ~rd_rdy)
            | (bus.rd_done & ~rd_rdy);
   end

   // Coefficient storage: write into the bank currently owned by the producer.
   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[{wr_ptr_q, bus.wr_addr}] <= bus.wr_data;
   end

   // Ownership state, error flag and the two registered read ports.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         full_cnt_q  <= '0;
         err_q       <= 1'b0;
         rd_vld_a_q  <= 1'b0;
         rd_vld_b_q  <= 1'b0;
         rd_data_a_q <= '0;
         rd_data_b_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         full_cnt_q <= full_cnt_d;
         err_q      <= err_d;
         rd_vld_a_q <= rd_a_acc;
         rd_vld_b_q <= rd_b_acc;
         // Read data holds its last value when no read is accepted.
         if (rd_a_acc) rd_data_a_q <= mem_q[{rd_ptr_q, bus.rd_addr_a}];
         if (rd_b_acc) rd_data_b_q <= mem_q[{rd_ptr_q, bus.rd_addr_b}];
      end
   end

   assign bus.wr_rdy    = wr_rdy;
   assign bus.rd_rdy    = rd_rdy;
   assign bus.full_cnt  = full_cnt_q;
   assign bus.err       = err_q;
   assign bus.rd_vld_a  = rd_vld_a_q;
   assign bus.rd_vld_b  = rd_vld_b_q;
   assign bus.rd_data_a = rd_data_a_q;
   assign bus.rd_data_b = rd_data_b_q;

endmodule
`default_nettype wire
